// File: rtl/ex_muldiv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ex_muldiv                                                  |
// | Description : Iterative RV M-extension unit: radix-2 shift-add multiply, |
// |               restoring divide. Divide path built only when macro        |
// |               EX_MULDIV_DIV_EN is defined.                               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ex_muldiv #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] reg1_i,
  input  logic [XLEN-1:0] reg2_i,
  input  logic [REGW-1:0] wd_i,
  input  logic            wreg_i,
  input  logic            flush_i,
  output logic            stallreq,
  output logic            valid_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [REGW-1:0] wd_o,
  output logic            wreg_o
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
`ifdef EX_MULDIV_DIV_EN
    S_DIV  = 2'd2,
`endif
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;
  logic              r_neg;
  logic [2:0]        r_funct3;
  logic [REGW-1:0]   r_wd;
  logic              r_wreg;
  logic [XLEN-1:0]   r_wdata;
  logic [REGW-1:0]   r_wd_o;

  // Operand sign handling at acceptance
  logic            w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag;

  assign w_a_signed = funct3_i[2] ? ~funct3_i[0] : (funct3_i[1] ^ funct3_i[0]);
  assign w_b_signed = funct3_i[2] ? ~funct3_i[0] : (funct3_i[1:0] == 2'b01);
  assign w_a_neg    = w_a_signed & reg1_i[XLEN-1];
  assign w_b_neg    = w_b_signed & reg2_i[XLEN-1];
  assign w_a_mag    = w_a_neg ? -reg1_i : reg1_i;
  assign w_b_mag    = w_b_neg ? -reg2_i : reg2_i;
  // Remainder takes the dividend sign; everything else the XOR of both
  assign w_neg      = (funct3_i[2] & funct3_i[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

  logic            w_special;
  logic [XLEN-1:0] w_special_res;

`ifdef EX_MULDIV_DIV_EN
  logic w_div0, w_ovf;
  assign w_div0        = (reg2_i == '0);
  assign w_ovf         = ~funct3_i[0] & (reg1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&reg2_i);
  assign w_special     = funct3_i[2] & (w_div0 | w_ovf);
  assign w_special_res = w_div0 ? (funct3_i[1] ? reg1_i : '1)
                                : (funct3_i[1] ? '0 : reg1_i);
`else
  assign w_special     = funct3_i[2];
  assign w_special_res = '0;
`endif

  logic w_accept, w_busy, w_finish;
  assign w_accept = (r_state == S_IDLE) & valid_i & ~flush_i;
`ifdef EX_MULDIV_DIV_EN
  assign w_busy   = (r_state == S_MUL) | (r_state == S_DIV);
`else
  assign w_busy   = (r_state == S_MUL);
`endif
  assign w_finish = w_busy & ~flush_i & (r_cnt == CW'(1));

  // Multiply step: multiplier lives in the low half and shifts out LSB first
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_mul_nx, w_prod, w_acc_nx;
  logic [XLEN-1:0]   w_mul_res, w_div_res, w_iter_res;

  assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_nx  = {w_sum, r_acc[XLEN-1:1]};
  assign w_prod    = r_neg ? -w_mul_nx : w_mul_nx;
  assign w_mul_res = (r_funct3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

`ifdef EX_MULDIV_DIV_EN
  // Restoring step: {remainder, dividend/quotient} shift left as one register
  logic [XLEN:0]     w_shift;
  logic [XLEN-1:0]   w_sub, w_quo, w_rem;
  logic              w_ge;
  logic [2*XLEN-1:0] w_div_nx;

  assign w_shift   = r_acc[2*XLEN-1:XLEN-1];
  assign w_ge      = (w_shift >= {1'b0, r_b});
  assign w_sub     = w_shift[XLEN-1:0] - r_b;
  assign w_div_nx  = w_ge ? {w_sub, r_acc[XLEN-2:0], 1'b1}
                          : {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
  assign w_quo     = w_div_nx[XLEN-1:0];
  assign w_rem     = w_div_nx[2*XLEN-1:XLEN];
  assign w_div_res = r_funct3[1] ? (r_neg ? -w_rem : w_rem) : (r_neg ? -w_quo : w_quo);
  assign w_acc_nx  = (r_state == S_DIV) ? w_div_nx : w_mul_nx;
`else
  assign w_div_res = '0;
  assign w_acc_nx  = w_mul_nx;
`endif

  assign w_iter_res = r_funct3[2] ? w_div_res : w_mul_res;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_special)         w_state_nx = S_DONE;
`ifdef EX_MULDIV_DIV_EN
          else if (funct3_i[2])  w_state_nx = S_DIV;
`endif
          else                   w_state_nx = S_MUL;
        end
      end
      S_MUL: begin
        if (flush_i)                  w_state_nx = S_IDLE;
        else if (r_cnt == CW'(1))     w_state_nx = S_DONE;
      end
`ifdef EX_MULDIV_DIV_EN
      S_DIV: begin
        if (flush_i)                  w_state_nx = S_IDLE;
        else if (r_cnt == CW'(1))     w_state_nx = S_DONE;
      end
`endif
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_neg    <= 1'b0;
      r_funct3 <= '0;
      r_wd     <= '0;
      r_wreg   <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= CW'(XLEN);
      r_acc    <= {{XLEN{1'b0}}, w_a_mag};
      r_b      <= w_b_mag;
      r_neg    <= w_neg;
      r_funct3 <= funct3_i;
      r_wd     <= wd_i;
      r_wreg   <= wreg_i;
    end else if (w_busy && !flush_i && r_cnt != '0) begin
      r_cnt    <= r_cnt - CW'(1);
      r_acc    <= w_acc_nx;
    end
  end

  // Writeback data is captured on the edge that enters DONE and held after
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdata <= '0;
      r_wd_o  <= '0;
    end else if (w_accept && w_special) begin
      r_wdata <= w_special_res;
      r_wd_o  <= wd_i;
    end else if (w_finish) begin
      r_wdata <= w_iter_res;
      r_wd_o  <= r_wd;
    end
  end

  assign stallreq = ~rst & (((r_state == S_IDLE) & valid_i & ~flush_i) | (w_busy & ~flush_i));
  assign valid_o  = (r_state == S_DONE) & ~flush_i;
  assign wreg_o   = valid_o & r_wreg;
  assign wdata_o  = r_wdata;
  assign wd_o     = r_wd_o;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ex_muldiv                                               |
// | Description : Directed self-checking bench for ex_muldiv (XLEN=32).      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [2:0]  funct3_i;
  logic [31:0] reg1_i, reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic        flush_i;
  logic        stallreq, valid_o, wreg_o;
  logic [31:0] wdata_o;
  logic [4:0]  wd_o;

  int n_checks = 0;
  int n_fail   = 0;

  ex_muldiv #(.XLEN(32), .REGW(5)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .funct3_i(funct3_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .flush_i(flush_i), .stallreq(stallreq), .valid_o(valid_o),
    .wdata_o(wdata_o), .wd_o(wd_o), .wreg_o(wreg_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, then verify latency, stall window, strobe and held data
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wd, input logic wr, input logic [31:0] exp,
                        input int lat, input string tag);
    int  n;
    bit  stall_ok;
    @(negedge clk);
    chk(valid_o, 1'b0, {tag, "_idle_valid"});
    valid_i = 1'b1; funct3_i = f3; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wr;
    #1 chk(stallreq, 1'b1, {tag, "_stall_accept"});
    @(posedge clk);
    #1 valid_i = 1'b0;
    n = 0;
    stall_ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n++;
      if (valid_o) break;
      if (!stallreq) stall_ok = 1'b0;
    end
    chk(n, lat, {tag, "_latency"});
    chk(stall_ok, 1'b1, {tag, "_stall_window"});
    chk(valid_o, 1'b1, {tag, "_valid"});
    chk(stallreq, 1'b0, {tag, "_stall_done"});
    chk(wdata_o, exp, {tag, "_wdata"});
    chk(wd_o, wd, {tag, "_wd"});
    chk(wreg_o, wr, {tag, "_wreg"});
    @(negedge clk);
    chk(valid_o, 1'b0, {tag, "_valid_pulse"});
    chk(wreg_o, 1'b0, {tag, "_wreg_after"});
    chk(wdata_o, exp, {tag, "_wdata_hold"});
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b1; funct3_i = 3'b000; reg1_i = 32'd3; reg2_i = 32'd4;
    wd_i = 5'd1; wreg_i = 1'b1; flush_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(stallreq, 1'b0, "rst_stall");
    chk(valid_o, 1'b0, "rst_valid");
    chk(wreg_o, 1'b0, "rst_wreg");
    chk(wd_o, 5'd0, "rst_wd");
    chk(wdata_o, 32'd0, "rst_wdata");
    valid_i = 1'b0;
    rst = 1'b0;

    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd3, 1'b1, 32'hFFFF_FFEB, 33, "mul");
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd4, 1'b1, 32'h4000_0000, 33, "mulh");
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1'b0, 32'hFFFF_FFFE, 33, "mulhu");
    run_op(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd6, 1'b1, 32'hFFFF_FFFF, 33, "mulhsu");

`ifdef EX_MULDIV_DIV_EN
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b1, 32'hFFFF_FFFD, 33, "div");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd8, 1'b1, 32'hFFFF_FFFF, 33, "rem");
    run_op(3'b101, 32'd100, 32'd7, 5'd9, 1'b1, 32'd14, 33, "divu");
    run_op(3'b111, 32'd100, 32'd7, 5'd10, 1'b1, 32'd2, 33, "remu");
    run_op(3'b101, 32'd5, 32'd0, 5'd11, 1'b1, 32'hFFFF_FFFF, 1, "divu0");
    run_op(3'b111, 32'd5, 32'd0, 5'd12, 1'b1, 32'd5, 1, "remu0");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b1, 32'h8000_0000, 1, "div_ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b1, 32'd0, 1, "rem_ovf");
`else
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b1, 32'd0, 1, "div_off");
    run_op(3'b111, 32'd100, 32'd7, 5'd10, 1'b1, 32'd0, 1, "remu_off");
`endif

    // Flush at t+10 of a MUL, then a new op from t+11
    @(negedge clk);
    valid_i = 1'b1; funct3_i = 3'b000; reg1_i = 32'd9; reg2_i = 32'd9; wd_i = 5'd20; wreg_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    #1 chk(stallreq, 1'b0, "flush_stall");
    chk(valid_o, 1'b0, "flush_valid");
    @(posedge clk);
    #1 flush_i = 1'b0;
    run_op(3'b000, 32'd6, 32'd7, 5'd21, 1'b1, 32'd42, 33, "after_flush");

    // Reset at t+5 of a MUL
    @(negedge clk);
    valid_i = 1'b1; funct3_i = 3'b011; reg1_i = 32'd9; reg2_i = 32'd9; wd_i = 5'd22; wreg_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1 chk(stallreq, 1'b0, "midrst_stall");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk(stallreq, 1'b0, "postrst_stall");
    chk(wdata_o, 32'd0, "postrst_wdata");
    chk(wd_o, 5'd0, "postrst_wd");
    run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd23, 1'b1, 32'd1, 33, "after_rst");

    // Flush in DONE suppresses the strobe and write enable
    @(negedge clk);
    valid_i = 1'b1; funct3_i = 3'b101; reg1_i = 32'd5; reg2_i = 32'd0; wd_i = 5'd24; wreg_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b1;
    #1 chk(valid_o, 1'b0, "done_flush_valid");
    chk(wreg_o, 1'b0, "done_flush_wreg");
    @(posedge clk);
    #1 flush_i = 1'b0;

    // valid_i together with flush_i in IDLE is not accepted
    @(negedge clk);
    valid_i = 1'b1; flush_i = 1'b1; funct3_i = 3'b000; reg1_i = 32'd2; reg2_i = 32'd2;
    #1 chk(stallreq, 1'b0, "idle_flush_stall");
    @(posedge clk);
    #1 begin valid_i = 1'b0; flush_i = 1'b0; end
    @(negedge clk);
    chk(stallreq, 1'b0, "idle_flush_noaccept");
    chk(valid_o, 1'b0, "idle_flush_valid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
